// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor
// Receive-side checker for a red/yellow/green traffic light interface.
// Samples the lamps, follows the red -> yellow -> green -> yellow -> red
// sequence, and flags bad lamp codes, bad phase order and wrong dwell times.
// It also counts completed signal cycles (legal YEL2 -> RED transitions).
module traffic_signal_monitor #(
    parameter int RED_LEN = 30,
    parameter int YEL_LEN = 5,
    parameter int GRN_LEN = 60,
    parameter int CNT_W   = 6,   // must hold GRN_LEN + 1
    parameter int CYC_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_len,
    output logic             err_any,
    output logic [CYC_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_RED  = 3'd1,
        ST_YEL1 = 3'd2,
        ST_GRN  = 3'd3,
        ST_YEL2 = 3'd4
    } state_e;

    // Lamp codes as {red, yellow, green}
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    logic [2:0]       smp_q;
    logic [2:0]       prev_q;
    state_e           state_q;
    logic [CNT_W-1:0] run_q;
    logic             partial_q;
    logic             locked_q;
    logic             err_onehot_q;
    logic             err_seq_q;
    logic             err_len_q;
    logic             err_any_q;
    logic [CYC_W-1:0] cycle_q;

    logic             changed;
    logic             onehot;
    logic [CNT_W-1:0] run_d;
    logic [CNT_W-1:0] phase_len;
    logic             legal;
    state_e           legal_next;

    // Input stage: one register of the lamp lines plus the sample before it
    // NOTE: sequential state is written only with non-blocking assignments, so
    // every register in the block sees the values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp_q  <= '0;
            prev_q <= '0;
        end else begin
            smp_q  <= {red, yellow, green};
            prev_q <= smp_q;
        end
    end

    assign changed = (smp_q != prev_q);
    assign onehot  = (smp_q == LAMP_R) || (smp_q == LAMP_Y) || (smp_q == LAMP_G);
    assign run_d   = (&run_q) ? run_q : run_q + 1'b1;

    // Required dwell and legal successor for the current phase
    // NOTE: every output of this block gets a default first so that no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        phase_len  = '0;
        legal      = 1'b0;
        legal_next = ST_SYNC;
        case (state_q)
            ST_RED: begin
                phase_len  = CNT_W'(RED_LEN);
                legal      = (smp_q == LAMP_Y);
                legal_next = ST_YEL1;
            end
            ST_YEL1: begin
                phase_len  = CNT_W'(YEL_LEN);
                legal      = (smp_q == LAMP_G);
                legal_next = ST_GRN;
            end
            ST_GRN: begin
                phase_len  = CNT_W'(GRN_LEN);
                legal      = (smp_q == LAMP_Y);
                legal_next = ST_YEL2;
            end
            ST_YEL2: begin
                phase_len  = CNT_W'(YEL_LEN);
                legal      = (smp_q == LAMP_R);
                legal_next = ST_RED;
            end
            default: begin
                phase_len  = '0;
                legal      = 1'b0;
                legal_next = ST_SYNC;
            end
        endcase
    end

    // Phase tracker: state, run counter, sticky errors and cycle count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SYNC;
            run_q        <= '0;
            partial_q    <= 1'b1;
            locked_q     <= 1'b0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_any_q    <= 1'b0;
            cycle_q      <= '0;
        end else begin
            err_any_q <= err_onehot_q | err_seq_q | err_len_q;

            if (state_q == ST_SYNC) begin
                // Lock onto red or green; yellow is ambiguous (YEL1 or YEL2)
                if (smp_q == LAMP_R || smp_q == LAMP_G) begin
                    state_q   <= (smp_q == LAMP_R) ? ST_RED : ST_GRN;
                    run_q     <= CNT_W'(1);
                    partial_q <= 1'b1;
                    locked_q  <= 1'b1;
                end else begin
                    run_q <= changed ? CNT_W'(1) : run_d;
                end
            end else if (!(state_q inside {ST_RED, ST_YEL1, ST_GRN, ST_YEL2})) begin
                // Unused encodings fall back to searching
                state_q   <= ST_SYNC;
                run_q     <= CNT_W'(1);
                partial_q <= 1'b1;
                locked_q  <= 1'b0;
            end else if (!onehot) begin
                err_onehot_q <= 1'b1;
                state_q      <= ST_SYNC;
                run_q        <= CNT_W'(1);
                partial_q    <= 1'b1;
                locked_q     <= 1'b0;
            end else if (changed) begin
                if (legal) begin
                    // A wrong dwell is flagged but the transition is still taken
                    if (!partial_q && run_q != phase_len) begin
                        err_len_q <= 1'b1;
                    end
                    if (state_q == ST_YEL2) begin
                        cycle_q <= cycle_q + 1'b1;
                    end
                    state_q   <= legal_next;
                    run_q     <= CNT_W'(1);
                    partial_q <= 1'b0;
                end else begin
                    err_seq_q <= 1'b1;
                    state_q   <= ST_SYNC;
                    run_q     <= CNT_W'(1);
                    partial_q <= 1'b1;
                    locked_q  <= 1'b0;
                end
            end else begin
                // Lamp held: reaching the full dwell with no change is an overrun
                if (!partial_q && run_q == phase_len) begin
                    err_len_q <= 1'b1;
                end
                run_q <= run_d;
            end
        end
    end

    assign phase       = state_q;
    assign locked      = locked_q;
    assign err_onehot  = err_onehot_q;
    assign err_seq     = err_seq_q;
    assign err_len     = err_len_q;
    assign err_any     = err_any_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: a default instance plus a CYC_W=2
// instance on the same lamps. Expected outputs are queued with the edge at
// which they are due and compared 1 time unit after that edge.
module tb_traffic_signal_monitor;

    localparam logic [2:0] OFF = 3'b000;
    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] RY  = 3'b110;

    typedef enum int {
        O_PHASE, O_LOCKED, O_ONEHOT, O_SEQ, O_LEN, O_ANY, O_CYC, O_CYCW
    } out_e;

    typedef struct {
        int          due;
        out_e        sel;
        logic [15:0] exp;
    } exp_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        red     = 1'b0;
    logic        yellow  = 1'b0;
    logic        green   = 1'b0;

    logic [2:0]  phase, phase_w;
    logic        locked, locked_w;
    logic        err_onehot, err_onehot_w;
    logic        err_seq, err_seq_w;
    logic        err_len, err_len_w;
    logic        err_any, err_any_w;
    logic [15:0] cycle_count;
    logic [1:0]  cycle_count_w;

    exp_t sb[$];
    int   edge_n  = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_cyc = 0;

    traffic_signal_monitor dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .phase       (phase),
        .locked      (locked),
        .err_onehot  (err_onehot),
        .err_seq     (err_seq),
        .err_len     (err_len),
        .err_any     (err_any),
        .cycle_count (cycle_count)
    );

    traffic_signal_monitor #(.CYC_W(2)) dut_w (
        .clk         (clk),
        .reset_n     (reset_n),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .phase       (phase_w),
        .locked      (locked_w),
        .err_onehot  (err_onehot_w),
        .err_seq     (err_seq_w),
        .err_len     (err_len_w),
        .err_any     (err_any_w),
        .cycle_count (cycle_count_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic [15:0] observe(input out_e sel);
        case (sel)
            O_PHASE:  return {13'd0, phase};
            O_LOCKED: return {15'd0, locked};
            O_ONEHOT: return {15'd0, err_onehot};
            O_SEQ:    return {15'd0, err_seq};
            O_LEN:    return {15'd0, err_len};
            O_ANY:    return {15'd0, err_any};
            O_CYC:    return cycle_count;
            default:  return {14'd0, cycle_count_w};
        endcase
    endfunction

    task automatic push(input int due, input out_e sel, input logic [15:0] exp);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Drive one lamp code across one rising edge, then score what is due
    task automatic tick(input logic [2:0] lamps);
        out_e s;
        {red, yellow, green} = lamps;
        @(posedge clk);
        edge_n++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_n) begin
                s = sb[i].sel;
                check(s.name(), {16'd0, observe(s)}, {16'd0, sb[i].exp});
                sb.delete(i);
            end
        end
    endtask

    task automatic seg(input logic [2:0] lamps, input int n);
        repeat (n) tick(lamps);
    endtask

    // One full light cycle; the caller must follow it with red
    task automatic gen_cycle(input int r, input int y1, input int g, input int y2);
        int k;
        k = edge_n + 1;
        exp_cyc++;
        push(k + r + 1, O_PHASE, 16'd2);
        push(k + r + y1 + 1, O_PHASE, 16'd3);
        push(k + r + y1 + g + 1, O_PHASE, 16'd4);
        push(k + r + y1 + g + y2 + 1, O_PHASE, 16'd1);
        push(k + r + y1 + g + y2 + 1, O_CYC, 16'(exp_cyc));
        push(k + r + y1 + g + y2 + 1, O_CYCW, 16'(exp_cyc % 4));
        seg(R, r);
        seg(Y, y1);
        seg(G, g);
        seg(Y, y2);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic pulse_reset(input logic [2:0] lamps);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_phase", {29'd0, phase}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_flags", {29'd0, err_onehot, err_seq, err_len}, 32'd0);
        check("rst_any", {31'd0, err_any}, 32'd0);
        check("rst_cyc", {16'd0, cycle_count}, 32'd0);
        check("rst_cycw", {30'd0, cycle_count_w}, 32'd0);
        exp_cyc = 0;
        tick(lamps);
        reset_n = 1'b1;
    endtask

    initial begin
        int k, kr, kx, kg, ky, kr2;

        // Reset state
        tick(OFF);
        tick(OFF);
        check("init_phase", {29'd0, phase}, 32'd0);
        check("init_locked", {31'd0, locked}, 32'd0);
        check("init_flags", {28'd0, err_onehot, err_seq, err_len, err_any}, 32'd0);
        check("init_cyc", {16'd0, cycle_count}, 32'd0);

        // Nominal: lock two edges after release, four cycles, no errors
        reset_n = 1'b1;
        push(edge_n + 1, O_LOCKED, 16'd0);
        push(edge_n + 2, O_LOCKED, 16'd1);
        push(edge_n + 2, O_PHASE, 16'd1);
        repeat (4) gen_cycle(30, 5, 60, 5);
        push(edge_n + 2, O_ONEHOT, 16'd0);
        push(edge_n + 2, O_SEQ, 16'd0);
        push(edge_n + 2, O_LEN, 16'd0);
        push(edge_n + 2, O_ANY, 16'd0);

        // Short green (59): err_len two edges after green->yellow
        k = edge_n + 1;
        push(k + 94, O_LEN, 16'd0);
        push(k + 95, O_LEN, 16'd1);
        push(k + 95, O_SEQ, 16'd0);
        push(k + 95, O_ANY, 16'd0);
        push(k + 96, O_ANY, 16'd1);
        gen_cycle(30, 5, 59, 5);
        gen_cycle(30, 5, 60, 5);
        push(edge_n + 37, O_PHASE, 16'd3);
        seg(R, 30);
        seg(Y, 5);
        seg(G, 20);

        // Reset mid-green, restart mid-yellow: stay in SYNC until red
        pulse_reset(Y);
        k = edge_n + 1;
        for (int i = 0; i < 5; i++) push(k + i, O_PHASE, 16'd0);
        seg(Y, 4);
        push(edge_n + 2, O_PHASE, 16'd1);
        push(edge_n + 2, O_LOCKED, 16'd1);
        seg(R, 12);
        seg(Y, 5);
        seg(G, 60);
        seg(Y, 5);

        // Long red (31): overrun flagged, phase stays RED, then legal exit
        kr = edge_n + 1;
        push(kr + 1, O_CYC, 16'd1);
        push(kr + 1, O_CYCW, 16'd1);
        push(kr + 1, O_LEN, 16'd0);
        push(kr + 30, O_LEN, 16'd0);
        push(kr + 31, O_LEN, 16'd1);
        push(kr + 31, O_PHASE, 16'd1);
        push(kr + 32, O_PHASE, 16'd2);
        seg(R, 31);
        seg(Y, 5);
        seg(G, 60);
        seg(Y, 5);

        // Bad encoding: red+yellow for one clock during red
        push(edge_n + 2, O_CYC, 16'd2);
        push(edge_n + 2, O_CYCW, 16'd2);
        seg(R, 10);
        kx = edge_n + 1;
        push(kx, O_ONEHOT, 16'd0);
        push(kx + 1, O_ONEHOT, 16'd1);
        push(kx + 1, O_SEQ, 16'd0);
        push(kx + 1, O_PHASE, 16'd0);
        push(kx + 1, O_LOCKED, 16'd0);
        push(kx + 2, O_PHASE, 16'd1);
        tick(RY);
        seg(R, 5);

        // Illegal order: red -> green, relock on green, partial unchecked
        pulse_reset(R);
        push(edge_n + 2, O_PHASE, 16'd1);
        seg(R, 12);
        seg(Y, 5);
        seg(G, 60);
        seg(Y, 5);
        push(edge_n + 2, O_CYC, 16'd1);
        seg(R, 30);
        kg = edge_n + 1;
        push(kg, O_SEQ, 16'd0);
        push(kg + 1, O_SEQ, 16'd1);
        push(kg + 1, O_PHASE, 16'd0);
        push(kg + 1, O_LOCKED, 16'd0);
        push(kg + 1, O_LEN, 16'd0);
        push(kg + 2, O_PHASE, 16'd3);
        push(kg + 2, O_LOCKED, 16'd1);
        seg(G, 20);
        ky = edge_n + 1;
        push(ky + 1, O_PHASE, 16'd4);
        seg(Y, 5);
        kr2 = edge_n + 1;
        push(kr2 + 1, O_PHASE, 16'd1);
        push(kr2 + 1, O_CYC, 16'd2);
        push(kr2 + 1, O_LEN, 16'd0);
        push(kr2 + 1, O_ONEHOT, 16'd0);
        seg(R, 3);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
